// File: rtl/out_drain_if.sv
// out_drain_if: groups the kernel-finish / normalize / dst-buffer signals of
// out_drain_ctrl. The optional DRAIN_STALL_CNT_EN macro adds stall_cnt.
// master: sample control and dst side. slave: the drain controller.
interface out_drain_if #(
    parameter int F_NUM = 16,
    parameter int AW    = 12
);
    localparam int RAW = $clog2(F_NUM);

    logic           k_fin;
    logic [AW-1:0]  base;
    logic [9:0]     os;
    logic [4:0]     fs;
    logic           hold;
    logic [RAW-1:0] ra;
    logic           nrm_en;
    logic           outr;
    logic [AW-1:0]  oa;
    logic           busy;
    logic           done;
    logic           overrun;
`ifdef DRAIN_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    modport master (
        output k_fin, base, os, fs, hold,
        input  ra, nrm_en, outr, oa, busy, done, overrun
`ifdef DRAIN_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  k_fin, base, os, fs, hold,
        output ra, nrm_en, outr, oa, busy, done, overrun
`ifdef DRAIN_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/out_drain_ctrl.sv
// out_drain_ctrl: after each kernel pass walks filters 0..fs-1, drives the
// normalize core select and emits dst-buffer writes aligned to the normalize
// pipeline output through an NRM_LAT-deep valid/address delay line.
// Optional feature macro: DRAIN_STALL_CNT_EN (adds a saturating stall counter).
module out_drain_ctrl #(
    parameter int F_NUM   = 16,
    parameter int AW      = 12,
    parameter int NRM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    out_drain_if.slave bus
);
    localparam int         RAW    = $clog2(F_NUM);
    localparam logic [4:0] FS_MAX = 5'(F_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [4:0]     fs_q, fs_d;
    logic [9:0]     os_q, os_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [RAW-1:0] ra_q, ra_d;
    logic           overrun_q, overrun_d;

    logic [NRM_LAT-1:0] lineValid_q;
    logic [AW-1:0]      lineAddr_q [NRM_LAT];

    logic       issue;
    logic       accept;
    logic       doneNow;
    logic       busyNow;
    logic       lineEmpty;
    logic       advance;
    logic [4:0] fsClamped;

    // Next-state logic: filter walk, k_fin acceptance (idle or done cycle) and overrun detection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fs_d      = fs_q;
        os_d      = os_q;
        addr_d    = addr_q;
        ra_d      = ra_q;
        overrun_d = overrun_q;
        issue     = 1'b0;
        accept    = 1'b0;
        doneNow   = 1'b0;
        busyNow   = (state_q != IDLE);
        advance   = ~bus.hold;
        lineEmpty = (lineValid_q == '0);
        fsClamped = (bus.fs > FS_MAX) ? FS_MAX : bus.fs;

        case (state_q)
            IDLE: begin
                accept = bus.k_fin;
            end
            DRAIN: begin
                if (!bus.hold) begin
                    issue  = 1'b1;
                    ra_d   = cnt_q[RAW-1:0];
                    addr_d = addr_q + AW'(os_q);
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == fs_q - 5'd1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (lineEmpty) begin
                    doneNow = 1'b1;
                    state_d = IDLE;
                    accept  = bus.k_fin;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            fs_d    = fsClamped;
            os_d    = bus.os;
            addr_d  = bus.base;
            cnt_d   = '0;
            state_d = (fsClamped != 5'd0) ? DRAIN : FLUSH;
        end else if (bus.k_fin && busyNow) begin
            overrun_d = 1'b1;
        end
    end

    // State and drain-context registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fs_q      <= '0;
            os_q      <= '0;
            addr_q    <= '0;
            ra_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fs_q      <= fs_d;
            os_q      <= os_d;
            addr_q    <= addr_d;
            ra_q      <= ra_d;
            overrun_q <= overrun_d;
        end
    end

    // Delay line tracking normalize latency; frozen together with the normalize unit on hold
    always_ff @(posedge clk) begin
        if (reset) begin
            lineValid_q <= '0;
            for (int i = 0; i < NRM_LAT; i++) begin
                lineAddr_q[i] <= '0;
            end
        end else if (advance) begin
            lineValid_q[0] <= issue;
            lineAddr_q[0]  <= addr_q;
            for (int i = 1; i < NRM_LAT; i++) begin
                lineValid_q[i] <= lineValid_q[i-1];
                lineAddr_q[i]  <= lineAddr_q[i-1];
            end
        end
    end

    assign bus.ra      = issue ? cnt_q[RAW-1:0] : ra_q;
    assign bus.nrm_en  = busyNow & ~bus.hold;
    assign bus.outr    = lineValid_q[NRM_LAT-1] & ~bus.hold;
    assign bus.oa      = bus.outr ? lineAddr_q[NRM_LAT-1] : '0;
    assign bus.busy    = busyNow;
    assign bus.done    = doneNow;
    assign bus.overrun = overrun_q;

`ifdef DRAIN_STALL_CNT_EN
    logic [15:0] stallCnt_q;

    // Saturating count of held busy cycles, restarted by every accepted k_fin
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else if (accept) begin
            stallCnt_q <= '0;
        end else if (busyNow && bus.hold && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_out_drain_ctrl.sv
// tb_out_drain_ctrl: directed-vector bench for out_drain_ctrl (F_NUM=16,
// AW=12, NRM_LAT=2). Cycle c=0 of each scenario is the k_fin cycle; inputs
// change 1ns after the rising edge and outputs are sampled on the falling edge.
module tb_out_drain_ctrl;
    localparam int F_NUM   = 16;
    localparam int AW      = 12;
    localparam int NRM_LAT = 2;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    out_drain_if #(.F_NUM(F_NUM), .AW(AW)) bus ();

    out_drain_ctrl #(.F_NUM(F_NUM), .AW(AW), .NRM_LAT(NRM_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10ns period
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic kf, input logic [AW-1:0] b,
                                 input logic [9:0] o, input logic [4:0] f,
                                 input logic h);
        @(posedge clk);
        #1;
        bus.k_fin = kf;
        bus.base  = b;
        bus.os    = o;
        bus.fs    = f;
        bus.hold  = h;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        vectors++; if (bus.ra !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_ra: got %0h expected 0", bus.ra); end
        vectors++; if (bus.nrm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_nrm_en: got %0b expected 0", bus.nrm_en); end
        vectors++; if (bus.outr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_outr: got %0b expected 0", bus.outr); end
        vectors++; if (bus.oa !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_oa: got %0h expected 0", bus.oa); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %0b expected 0", bus.overrun); end
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
    endtask

    // fs=16, base=0x010, os=0x040, no hold: outr cycles 3..18, done cycle 19
    task automatic test_full_drain();
        int            outrCount = 0;
        int            doneCount = 0;
        logic          expOutr;
        logic          expBusy;
        logic [AW-1:0] expOa;
        for (int c = 0; c < 23; c++) begin
            applyStimulus(c == 0, 12'h010, 10'h040, 5'd16, 1'b0);
            @(negedge clk);
            expBusy = (c >= 1 && c <= 19);
            expOutr = (c >= 3 && c <= 18);
            expOa   = 12'h010 + 12'(c - 3) * 12'h040;
            vectors++; if (bus.outr !== expOutr) begin miscompares++; $display("[TB] FAIL full_outr c=%0d: got %0b expected %0b", c, bus.outr, expOutr); end
            if (expOutr) begin
                vectors++; if (bus.oa !== expOa) begin miscompares++; $display("[TB] FAIL full_oa c=%0d: got %0h expected %0h", c, bus.oa, expOa); end
            end
            if (c >= 1 && c <= 16) begin
                vectors++; if (bus.ra !== 4'(c - 1)) begin miscompares++; $display("[TB] FAIL full_ra c=%0d: got %0d expected %0d", c, bus.ra, c - 1); end
            end
            vectors++; if (bus.done !== (c == 19)) begin miscompares++; $display("[TB] FAIL full_done c=%0d: got %0b expected %0b", c, bus.done, c == 19); end
            vectors++; if (bus.busy !== expBusy || bus.nrm_en !== expBusy) begin miscompares++; $display("[TB] FAIL full_busy c=%0d: got busy=%0b nrm_en=%0b expected %0b", c, bus.busy, bus.nrm_en, expBusy); end
            if (bus.outr === 1'b1) outrCount++;
            if (bus.done === 1'b1) doneCount++;
        end
        vectors++; if (outrCount != 16 || doneCount != 1) begin miscompares++; $display("[TB] FAIL full_counts: got outr=%0d done=%0d expected 16 1", outrCount, doneCount); end
    endtask

    // fs=4 with hold in cycles 2..4: issues 1,5,6,7; outr 6..9; done 10
    task automatic test_hold();
        logic          h;
        logic          expBusy;
        logic          expOutr;
        logic [3:0]    expRa;
        logic [AW-1:0] expOa;
        for (int c = 0; c < 14; c++) begin
            h = (c >= 2 && c <= 4);
            applyStimulus(c == 0, 12'h100, 10'h004, 5'd4, h);
            @(negedge clk);
            expBusy = (c >= 1 && c <= 10);
            expOutr = (c >= 6 && c <= 9);
            expOa   = 12'h100 + 12'(c - 6) * 12'h004;
            expRa   = (c <= 4) ? 4'd0 : ((c <= 7) ? 4'(c - 4) : 4'd3);
            vectors++; if (bus.outr !== expOutr) begin miscompares++; $display("[TB] FAIL hold_outr c=%0d: got %0b expected %0b", c, bus.outr, expOutr); end
            if (expOutr) begin
                vectors++; if (bus.oa !== expOa) begin miscompares++; $display("[TB] FAIL hold_oa c=%0d: got %0h expected %0h", c, bus.oa, expOa); end
            end
            if (c >= 1 && c <= 10) begin
                vectors++; if (bus.ra !== expRa) begin miscompares++; $display("[TB] FAIL hold_ra c=%0d: got %0d expected %0d", c, bus.ra, expRa); end
            end
            vectors++; if (bus.nrm_en !== (expBusy && !h)) begin miscompares++; $display("[TB] FAIL hold_nrm_en c=%0d: got %0b expected %0b", c, bus.nrm_en, expBusy && !h); end
            vectors++; if (bus.done !== (c == 10)) begin miscompares++; $display("[TB] FAIL hold_done c=%0d: got %0b expected %0b", c, bus.done, c == 10); end
`ifdef DRAIN_STALL_CNT_EN
            if (c == 13) begin
                vectors++; if (bus.stall_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL hold_stall_cnt: got %0d expected 3", bus.stall_cnt); end
            end
`endif
        end
    endtask

    // base=0xFF0, os=0x010, fs=3, hold in cycle 4: oa FF0@3, 000@5, 010@6, done 7
    task automatic test_wrap();
        logic          h;
        logic          expBusy;
        logic          expOutr;
        logic [AW-1:0] expOa;
        for (int c = 0; c < 11; c++) begin
            h = (c == 4);
            applyStimulus(c == 0, 12'hFF0, 10'h010, 5'd3, h);
            @(negedge clk);
            expBusy = (c >= 1 && c <= 7);
            expOutr = 1'b0;
            expOa   = 12'h000;
            case (c)
                3: begin expOutr = 1'b1; expOa = 12'hFF0; end
                5: begin expOutr = 1'b1; expOa = 12'h000; end
                6: begin expOutr = 1'b1; expOa = 12'h010; end
                default: ;
            endcase
            vectors++; if (bus.outr !== expOutr) begin miscompares++; $display("[TB] FAIL wrap_outr c=%0d: got %0b expected %0b", c, bus.outr, expOutr); end
            if (expOutr) begin
                vectors++; if (bus.oa !== expOa) begin miscompares++; $display("[TB] FAIL wrap_oa c=%0d: got %0h expected %0h", c, bus.oa, expOa); end
            end
            vectors++; if (bus.busy !== expBusy || bus.nrm_en !== (expBusy && !h)) begin miscompares++; $display("[TB] FAIL wrap_busy c=%0d: got busy=%0b nrm_en=%0b expected busy=%0b", c, bus.busy, bus.nrm_en, expBusy); end
            vectors++; if (bus.done !== (c == 7)) begin miscompares++; $display("[TB] FAIL wrap_done c=%0d: got %0b expected %0b", c, bus.done, c == 7); end
`ifdef DRAIN_STALL_CNT_EN
            if (c == 10) begin
                vectors++; if (bus.stall_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL wrap_stall_cnt: got %0d expected 1", bus.stall_cnt); end
            end
`endif
        end
    endtask

    // fs=0: busy and done only in cycle 1, never outr
    task automatic test_empty();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(c == 0, 12'h123, 10'h005, 5'd0, 1'b0);
            @(negedge clk);
            vectors++; if (bus.outr !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_outr c=%0d: got %0b expected 0", c, bus.outr); end
            vectors++; if (bus.busy !== (c == 1)) begin miscompares++; $display("[TB] FAIL empty_busy c=%0d: got %0b expected %0b", c, bus.busy, c == 1); end
            vectors++; if (bus.done !== (c == 1)) begin miscompares++; $display("[TB] FAIL empty_done c=%0d: got %0b expected %0b", c, bus.done, c == 1); end
        end
    endtask

    // fs=20 clamps to 16: sixteen writes, last ra 15 in cycle 16, done cycle 19
    task automatic test_clamp();
        int outrCount = 0;
        for (int c = 0; c < 22; c++) begin
            applyStimulus(c == 0, 12'h000, 10'h001, 5'd20, 1'b0);
            @(negedge clk);
            if (bus.outr === 1'b1) outrCount++;
            if (c == 16) begin
                vectors++; if (bus.ra !== 4'd15) begin miscompares++; $display("[TB] FAIL clamp_ra: got %0d expected 15", bus.ra); end
            end
            vectors++; if (bus.done !== (c == 19)) begin miscompares++; $display("[TB] FAIL clamp_done c=%0d: got %0b expected %0b", c, bus.done, c == 19); end
        end
        vectors++; if (outrCount != 16) begin miscompares++; $display("[TB] FAIL clamp_outr_count: got %0d expected 16", outrCount); end
    endtask

    // k_fin on the done cycle (c=5) starts the next drain directly; overrun stays 0
    task automatic test_back_to_back();
        logic          expOutr;
        logic [AW-1:0] expOa;
        for (int c = 0; c < 14; c++) begin
            if (c < 5) applyStimulus(c == 0, 12'h300, 10'h020, 5'd2, 1'b0);
            else       applyStimulus(c == 5, 12'h080, 10'h001, 5'd3, 1'b0);
            @(negedge clk);
            expOutr = 1'b0;
            expOa   = 12'h000;
            case (c)
                3:  begin expOutr = 1'b1; expOa = 12'h300; end
                4:  begin expOutr = 1'b1; expOa = 12'h320; end
                8:  begin expOutr = 1'b1; expOa = 12'h080; end
                9:  begin expOutr = 1'b1; expOa = 12'h081; end
                10: begin expOutr = 1'b1; expOa = 12'h082; end
                default: ;
            endcase
            vectors++; if (bus.outr !== expOutr) begin miscompares++; $display("[TB] FAIL b2b_outr c=%0d: got %0b expected %0b", c, bus.outr, expOutr); end
            if (expOutr) begin
                vectors++; if (bus.oa !== expOa) begin miscompares++; $display("[TB] FAIL b2b_oa c=%0d: got %0h expected %0h", c, bus.oa, expOa); end
            end
            if (c == 6 || c == 7 || c == 8) begin
                vectors++; if (bus.ra !== 4'(c - 6)) begin miscompares++; $display("[TB] FAIL b2b_ra c=%0d: got %0d expected %0d", c, bus.ra, c - 6); end
            end
            vectors++; if (bus.busy !== (c >= 1 && c <= 11)) begin miscompares++; $display("[TB] FAIL b2b_busy c=%0d: got %0b expected %0b", c, bus.busy, c >= 1 && c <= 11); end
            vectors++; if (bus.done !== (c == 5 || c == 11)) begin miscompares++; $display("[TB] FAIL b2b_done c=%0d: got %0b expected %0b", c, bus.done, c == 5 || c == 11); end
            vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun c=%0d: got %0b expected 0", c, bus.overrun); end
        end
    endtask

    // k_fin in DRAIN (c=2) is ignored and sets sticky overrun from c=3
    task automatic test_overrun();
        logic expOutr;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) applyStimulus(1'b1, 12'h7FF, 10'h001, 5'd1, 1'b0);
            else        applyStimulus(c == 0, 12'h000, 10'h001, 5'd4, 1'b0);
            @(negedge clk);
            expOutr = (c >= 3 && c <= 6);
            vectors++; if (bus.outr !== expOutr) begin miscompares++; $display("[TB] FAIL ovr_outr c=%0d: got %0b expected %0b", c, bus.outr, expOutr); end
            if (expOutr) begin
                vectors++; if (bus.oa !== 12'(c - 3)) begin miscompares++; $display("[TB] FAIL ovr_oa c=%0d: got %0h expected %0h", c, bus.oa, c - 3); end
            end
            vectors++; if (bus.done !== (c == 7)) begin miscompares++; $display("[TB] FAIL ovr_done c=%0d: got %0b expected %0b", c, bus.done, c == 7); end
            vectors++; if (bus.overrun !== (c >= 3)) begin miscompares++; $display("[TB] FAIL ovr_overrun c=%0d: got %0b expected %0b", c, bus.overrun, c >= 3); end
        end
    endtask

    // reset during cycle 5 of a 16-filter drain: everything 0 from cycle 6 on
    task automatic test_reset_mid_drain();
        for (int c = 0; c < 26; c++) begin
            applyStimulus(c == 0, 12'h000, 10'h001, 5'd16, 1'b0);
            reset = (c == 5);
            @(negedge clk);
            if (c == 5) begin
                vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_busy_before: got %0b expected 1", bus.busy); end
            end
            if (c == 6) begin
                vectors++; if (bus.ra !== 4'd0) begin miscompares++; $display("[TB] FAIL rmid_ra: got %0h expected 0", bus.ra); end
                vectors++; if (bus.nrm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_nrm_en: got %0b expected 0", bus.nrm_en); end
                vectors++; if (bus.oa !== 12'h000) begin miscompares++; $display("[TB] FAIL rmid_oa: got %0h expected 0", bus.oa); end
                vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_overrun: got %0b expected 0", bus.overrun); end
            end
            if (c >= 6) begin
                vectors++; if (bus.outr !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_quiet c=%0d: got outr=%0b done=%0b busy=%0b expected 0 0 0", c, bus.outr, bus.done, bus.busy); end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.k_fin = 1'b0;
        bus.base  = '0;
        bus.os    = '0;
        bus.fs    = '0;
        bus.hold  = 1'b0;
        $display("[TB] out_drain_ctrl directed vectors");
        test_reset();
        test_full_drain();
        test_hold();
        test_wrap();
        test_empty();
        test_clamp();
        test_back_to_back();
        test_overrun();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
